// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// One operand bit per cycle: shift-add multiply, restoring divide, sign fix-up at the end.
module muldiv_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        flush,
  input  logic        hiWrite,
  input  logic        loWrite,
  input  logic [31:0] wrData,
  output logic        busy,
  output logic        done,
  output logic        divZero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  // Handshake: start is taken only in IDLE when flush is low; busy covers
  // the start edge through the FINISH edge, and done pulses for one cycle.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] opnd_q;      // |A| for multiply, |B| for divide
  logic [31:0] dividend_q;  // raw A, returned in HI on divide-by-zero
  logic [63:0] acc_q;       // {hi part, lo part} of the running product or {rem, quotient}
  logic        neg_q;       // result (product or quotient) is negative
  logic        rneg_q;      // remainder is negative
  logic        bzero_q;

  logic        accept, finish_ok, mt_ok;
  logic        in_signed, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next, prod;
  logic [32:0] div_sh, div_diff;
  logic [31:0] quo, rem;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush)              state_d = IDLE;
        else if (cnt_q == 5'd31) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign finish_ok = (state_q == FINISH) && !flush;
  assign mt_ok     = (state_q == IDLE) && !flush && !start;
  assign state_dbg = state_q;

  // Operand magnitudes at capture time; unsigned ops never see a sign.
  assign in_signed = ~op[0];
  assign sa        = in_signed & inA[31];
  assign sb        = in_signed & inB[31];
  assign mag_a     = sa ? (~inA + 32'd1) : inA;
  assign mag_b     = sb ? (~inB + 32'd1) : inB;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  assign div_sh   = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_next = (div_sh >= {1'b0, opnd_q}) ? {div_diff[31:0], acc_q[30:0], 1'b1}
                                               : {div_sh[31:0], acc_q[30:0], 1'b0};

  assign prod = neg_q  ? (~acc_q + 64'd1) : acc_q;
  assign quo  = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem  = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q      <= 5'd0;
      op_q       <= 2'd0;
      opnd_q     <= 32'd0;
      dividend_q <= 32'd0;
      acc_q      <= 64'd0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      bzero_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      divZero    <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      if (accept) begin
        cnt_q      <= 5'd0;
        op_q       <= op;
        dividend_q <= inA;
        bzero_q    <= (inB == 32'd0);
        neg_q      <= sa ^ sb;
        rneg_q     <= sa;
        opnd_q     <= op[1] ? mag_b : mag_a;
        acc_q      <= {32'd0, op[1] ? mag_a : mag_b};
        busy       <= 1'b1;
      end else if (state_q == RUN) begin
        if (flush) begin
          busy <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 5'd1;
          acc_q <= op_q[1] ? div_next : mul_next;
        end
      end else if (state_q == FINISH) begin
        busy <= 1'b0;
        if (finish_ok) begin
          done <= 1'b1;
          if (!op_q[1]) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end else if (bzero_q) begin
            hi      <= dividend_q;
            lo      <= 32'hFFFF_FFFF;
            divZero <= 1'b1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
      end else if (mt_ok) begin
        if (hiWrite) hi <= wrData;
        if (loWrite) lo <= wrData;
      end
    end
  end

endmodule
